// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: active-low patterns (bit0=a .. bit6=g)
// and the scan-decoder FSM state type.
package sevenseg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        SETTLE  = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } scan_state_e;

endpackage

// File: rtl/sevenseg_pattern_decode.sv
// Combinational inverse of the display encoder: 7-bit active-low pattern to
// {hit, blank, nibble}.
module sevenseg_pattern_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       hit,
    output logic       blank,
    output logic [3:0] nibble
);

    // Pattern lookup; anything not in the table is neither a hit nor blank.
    always_comb begin
        hit    = 1'b1;
        blank  = 1'b0;
        nibble = 4'h0;
        case (pattern)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_A:     nibble = 4'hA;
            SEG_B:     nibble = 4'hB;
            SEG_C:     nibble = 4'hC;
            SEG_D:     nibble = 4'hD;
            SEG_E:     nibble = 4'hE;
            SEG_F:     nibble = 4'hF;
            SEG_BLANK: begin
                hit   = 1'b0;
                blank = 1'b1;
            end
            default:   hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Snoops a multiplexed active-low seven-segment bus and decodes stable digits
// into a per-digit register file. Optional saturating error counter: SEVENSEG_ERRCNT_EN.
module sevenseg_scan_decoder
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clock,
    input  logic                    reset_L,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an_L,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_done,
    output logic                    pattern_err
`ifdef SEVENSEG_ERRCNT_EN
    ,
    output logic [7:0]              err_count
`endif
);

    localparam int SW = 7 + NUM_DIGITS;
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [SW-1:0]           bus_s, s_q;
    logic [CW-1:0]           cnt_d, cnt_q;
    scan_state_e             state_d, state_q;
    logic [NUM_DIGITS-1:0]   sel_s;
    logic                    change_s, onehot_s, capture_s;
    logic                    hit_s, blank_s;
    logic [3:0]              nibble_s;
    logic [4*NUM_DIGITS-1:0] hex_d, hex_q;
    logic [NUM_DIGITS-1:0]   valid_d, valid_q, seen_d, seen_q;
    logic                    fdone_d, fdone_q, perr_d, perr_q;
`ifdef SEVENSEG_ERRCNT_EN
    logic [7:0]              ec_d, ec_q;
`endif

    assign bus_s    = {seg, an_L};
    assign change_s = (bus_s != s_q);
    assign sel_s    = ~s_q[NUM_DIGITS-1:0];
    assign onehot_s = (sel_s != {NUM_DIGITS{1'b0}}) &&
                      ((sel_s & (sel_s - NUM_DIGITS'(1))) == {NUM_DIGITS{1'b0}});

    sevenseg_pattern_decode u_decode (
        .pattern (s_q[SW-1:NUM_DIGITS]),
        .hit     (hit_s),
        .blank   (blank_s),
        .nibble  (nibble_s)
    );

    // Stability counter: restarts on any bus change, saturates at the threshold.
    always_comb begin
        if (change_s) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Capture FSM. A change seen during CAPTURE (counter already restarted)
    // goes straight back to SETTLE so it cannot be lost for short thresholds.
    always_comb begin
        state_d   = state_q;
        capture_s = 1'b0;
        case (state_q)
            SETTLE: begin
                if ((cnt_q == CNT_MAX) && onehot_s) begin
                    state_d   = CAPTURE;
                    capture_s = 1'b1;
                end else begin
                    state_d   = SETTLE;
                end
            end
            CAPTURE: begin
                if (change_s || (cnt_q != CNT_MAX)) begin
                    state_d = SETTLE;
                end else begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (change_s || (cnt_q != CNT_MAX)) begin
                    state_d = SETTLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: state_d = SETTLE;
        endcase
    end

    // Result register file, frame tracking and error pulse; clear beats capture.
    always_comb begin
        hex_d   = hex_q;
        valid_d = valid_q;
        seen_d  = seen_q;
        fdone_d = 1'b0;
        perr_d  = 1'b0;
        if (clear) begin
            hex_d   = {(4*NUM_DIGITS){1'b0}};
            valid_d = {NUM_DIGITS{1'b0}};
            seen_d  = {NUM_DIGITS{1'b0}};
        end else begin
            if (&seen_q) begin
                fdone_d = 1'b1;
                seen_d  = {NUM_DIGITS{1'b0}};
            end else begin
                fdone_d = 1'b0;
            end
            if (capture_s) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (sel_s[i]) begin
                        seen_d[i] = 1'b1;
                        if (hit_s) begin
                            hex_d[4*i +: 4] = nibble_s;
                            valid_d[i]      = 1'b1;
                        end else begin
                            valid_d[i] = 1'b0;
                            perr_d     = ~blank_s;
                        end
                    end else begin
                        seen_d[i] = seen_d[i];
                    end
                end
            end else begin
                perr_d = 1'b0;
            end
        end
    end

`ifdef SEVENSEG_ERRCNT_EN
    // Saturating error counter.
    always_comb begin
        if (clear) begin
            ec_d = 8'h00;
        end else if (perr_d && (ec_q != 8'hFF)) begin
            ec_d = ec_q + 8'h01;
        end else begin
            ec_d = ec_q;
        end
    end
`endif

    // State registers.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            s_q     <= {SW{1'b1}};
            cnt_q   <= {CW{1'b0}};
            state_q <= SETTLE;
            hex_q   <= {(4*NUM_DIGITS){1'b0}};
            valid_q <= {NUM_DIGITS{1'b0}};
            seen_q  <= {NUM_DIGITS{1'b0}};
            fdone_q <= 1'b0;
            perr_q  <= 1'b0;
`ifdef SEVENSEG_ERRCNT_EN
            ec_q    <= 8'h00;
`endif
        end else begin
            s_q     <= bus_s;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            hex_q   <= hex_d;
            valid_q <= valid_d;
            seen_q  <= seen_d;
            fdone_q <= fdone_d;
            perr_q  <= perr_d;
`ifdef SEVENSEG_ERRCNT_EN
            ec_q    <= ec_d;
`endif
        end
    end

    assign hex_out     = hex_q;
    assign digit_valid = valid_q;
    assign frame_done  = fdone_q;
    assign pattern_err = perr_q;
`ifdef SEVENSEG_ERRCNT_EN
    assign err_count   = ec_q;
`endif

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Scoreboard bench for sevenseg_scan_decoder: directed bus scans with expected
// output snapshots queued per clock edge and checked by an independent monitor.
module tb_sevenseg_scan_decoder;
    import sevenseg_pkg::*;

    logic        clock = 1'b0;
    logic        reset_L;
    logic        clear;
    logic [6:0]  seg;
    logic [7:0]  an_L;
    logic [31:0] hex_out;
    logic [7:0]  digit_valid;
    logic        frame_done;
    logic        pattern_err;
`ifdef SEVENSEG_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    sevenseg_scan_decoder #(.NUM_DIGITS(8), .STABLE_CYCLES(4)) dut (
        .clock       (clock),
        .reset_L     (reset_L),
        .seg         (seg),
        .an_L        (an_L),
        .clear       (clear),
        .hex_out     (hex_out),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .pattern_err (pattern_err)
`ifdef SEVENSEG_ERRCNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    typedef struct {
        int          cyc;
        logic [31:0] hex;
        logic [7:0]  valid;
        logic        perr;
        logic        fdone;
        logic [7:0]  ec;
    } exp_t;

    exp_t        sbq[$];
    int          edge_cnt = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_hex;
    logic [7:0]  exp_valid;
    logic [7:0]  exp_ec;

    logic [6:0]  dig_tab   [8] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7};
    logic [31:0] scan_hex  [8] = '{32'h00000000, 32'h00000010, 32'h00000210, 32'h00003210,
                                   32'h00043210, 32'h00543210, 32'h06543210, 32'h76543210};
    logic [7:0]  scan_vld  [8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};

    always #5 clock = ~clock;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, edge_cnt, act, exp);
        end
    endtask

    task automatic push(input int cyc, input logic perr, input logic fdone);
        exp_t e;
        e.cyc   = cyc;
        e.hex   = exp_hex;
        e.valid = exp_valid;
        e.perr  = perr;
        e.fdone = fdone;
        e.ec    = exp_ec;
        sbq.push_back(e);
    endtask

    task automatic apply(input logic [6:0] sg, input logic [7:0] an, input int hold);
        seg  = sg;
        an_L = an;
        repeat (hold) @(negedge clock);
    endtask

    // Monitor: full snapshot on scheduled edges, pulses must stay low otherwise.
    always @(negedge clock) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].cyc < edge_cnt) begin
            e = sbq.pop_front();
            check_val("missed_slot", edge_cnt, e.cyc);
        end
        if (sbq.size() > 0 && sbq[0].cyc == edge_cnt) begin
            e = sbq.pop_front();
            check_val("hex_out", hex_out, e.hex);
            check_val("digit_valid", digit_valid, e.valid);
            check_val("pattern_err", pattern_err, e.perr);
            check_val("frame_done", frame_done, e.fdone);
`ifdef SEVENSEG_ERRCNT_EN
            check_val("err_count", err_count, e.ec);
`endif
        end else begin
            check_val("idle_pattern_err", pattern_err, 1'b0);
            check_val("idle_frame_done", frame_done, 1'b0);
        end
    end

    initial begin
        int e;
        int w;
        reset_L   = 1'b0;
        clear     = 1'b0;
        seg       = SEG_3;
        an_L      = 8'hFE;
        exp_hex   = 32'h0;
        exp_valid = 8'h00;
        exp_ec    = 8'h00;

        // Reset with digit 0 = 3 driven; capture lands 5 edges after release.
        @(negedge clock);
        e = edge_cnt;
        push(e + 1, 1'b0, 1'b0);
        push(e + 2, 1'b0, 1'b0);
        repeat (3) @(negedge clock);
        reset_L = 1'b1;
        e = edge_cnt;
        for (int k = 1; k <= 4; k++) push(e + k, 1'b0, 1'b0);
        exp_hex   = 32'h00000003;
        exp_valid = 8'h01;
        push(e + 5, 1'b0, 1'b0);
        repeat (6) @(negedge clock);

        // Idle bus then clear.
        seg  = SEG_BLANK;
        an_L = 8'hFF;
        repeat (2) @(negedge clock);
        clear     = 1'b1;
        e         = edge_cnt;
        exp_hex   = 32'h0;
        exp_valid = 8'h00;
        push(e + 1, 1'b0, 1'b0);
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);

        // Glitch: 3 edges is too short to capture.
        e = edge_cnt;
        push(e + 3, 1'b0, 1'b0);
        apply(SEG_3, 8'hFE, 3);
        e = edge_cnt;
        push(e + 6, 1'b0, 1'b0);
        apply(SEG_BLANK, 8'hFF, 6);

        // Full scan 0..7; frame_done one edge after digit 7 capture.
        for (int k = 0; k < 8; k++) begin
            e         = edge_cnt;
            exp_hex   = scan_hex[k];
            exp_valid = scan_vld[k];
            push(e + 5, 1'b0, 1'b0);
            if (k == 7) push(e + 6, 1'b0, 1'b1);
            apply(dig_tab[k], ~(8'h01 << k), 6);
        end

        // Undecodable pattern on digit 2.
        e         = edge_cnt;
        exp_valid = 8'hFB;
        exp_ec    = 8'h01;
        push(e + 5, 1'b1, 1'b0);
        apply(7'h55, 8'hFB, 6);

        // Blank on digit 3: invalid, no error.
        e         = edge_cnt;
        exp_valid = 8'hF3;
        push(e + 5, 1'b0, 1'b0);
        apply(SEG_BLANK, 8'hF7, 6);

        // Two selects low: never captured.
        e = edge_cnt;
        push(e + 5, 1'b0, 1'b0);
        push(e + 10, 1'b0, 1'b0);
        apply(SEG_5, 8'hFC, 10);

        // Clear on the capture edge wins; steady bus is not recaptured.
        e         = edge_cnt;
        exp_hex   = 32'h0;
        exp_valid = 8'h00;
        exp_ec    = 8'h00;
        push(e + 5, 1'b0, 1'b0);
        push(e + 12, 1'b0, 1'b0);
        apply(SEG_9, 8'hBF, 4);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        repeat (7) @(negedge clock);

        // Normal captures resume afterwards.
        e         = edge_cnt;
        exp_hex   = 32'h0A000000;
        exp_valid = 8'h40;
        push(e + 5, 1'b0, 1'b0);
        apply(SEG_A, 8'hBF, 6);
        e         = edge_cnt;
        exp_hex   = 32'hFA000000;
        exp_valid = 8'hC0;
        push(e + 5, 1'b0, 1'b0);
        apply(SEG_F, 8'h7F, 6);

        w = 0;
        while (sbq.size() > 0 && w < 20) begin
            @(negedge clock);
            w++;
        end
        check_val("queue_drained", sbq.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan_decoder.md
# sevenseg_scan_decoder

Receive-side counterpart of the BCD-to-seven-segment path. It snoops a time-multiplexed, active-low seven-segment display bus (segment lines plus per-digit select lines), filters out transient patterns, and decodes each stable lit pattern back into a 4-bit hex value. Results go into a per-digit register file, along with validity, frame-complete and bad-pattern indications. It sits between the board's display bus pins and the self-test/readback logic.

## Interface
- NUM_DIGITS, 8, number of multiplexed digits (2..16)
- STABLE_CYCLES, 4, consecutive identical samples required before capture (≥2)
- clock  input  1  system clock, rising edge
- reset_L  input  1  asynchronous, active-low reset
- seg  input  7  segment lines, active-low, bit0=a … bit6=g
- an_L  input  NUM_DIGITS  digit selects, active-low, exactly one low when a digit is driven
- clear  input  1  synchronous clear of captured results
- hex_out  output  4*NUM_DIGITS  decoded nibbles; digit i at [4i+3:4i]
- digit_valid  output  NUM_DIGITS  1 = digit i holds a decoded 0–F value
- frame_done  output  1  one-cycle pulse when every digit has been captured since the last pulse
- pattern_err  output  1  one-cycle pulse on capture of an undecodable pattern
- err_count  output  8  saturating error count (only with SEVENSEG_ERRCNT_EN)

## Operation
- Input stage: {seg, an_L} is registered into s_q on every edge (sync stage).
- Stability counter cnt, width clog2(STABLE_CYCLES):
  - New input ≠ s_q: cnt←0.
  - Otherwise cnt increments, saturating at STABLE_CYCLES-1.
- FSM states:
  - SETTLE → CAPTURE when cnt==STABLE_CYCLES-1 and an_L in s_q is one-hot-low.
  - CAPTURE (one cycle) → HOLD.
  - HOLD → SETTLE on any input change.
  - SETTLE → SETTLE on change (cnt restarts).
  - a non-one-hot an_L (all high or several low) never leaves SETTLE.
- Decode in CAPTURE, for the selected digit d:
  - One of the 16 hex patterns (encoding identical to the display encoder, 0=1000000 … F=0001110): hex_out[d]←value, digit_valid[d]←1.
  - 1111111 (blank): digit_valid[d]←0, hex_out[d] unchanged, no error.
  - Any other pattern: digit_valid[d]←0, hex_out[d] unchanged, pattern_err pulses.
  - In all three cases seen[d]←1.
- Frame completion: when seen becomes all-ones, frame_done pulses on the following edge and seen clears in that same edge. A digit captured twice before the frame completes is simply overwritten.
- clear:
  - Zeroes hex_out, digit_valid, seen and err_count.
  - Does not disturb s_q, cnt or the FSM.
  - clear coinciding with a capture: clear wins and the capture is discarded; the FSM still goes to HOLD, so the same steady pattern is not recaptured.

## Timing
- Reset values: hex_out=0, digit_valid=0, frame_done=0, pattern_err=0, err_count=0, s_q=all ones, cnt=0, seen=0, FSM=SETTLE.
- Capture latency: input changes and is then held. hex_out, digit_valid and pattern_err update on the (STABLE_CYCLES+1)th rising edge after the change.
  - Default: edge 5.
- Glitch rule: a pattern held for ≤STABLE_CYCLES-1 edges is never captured.
- frame_done is high one cycle after the edge that captured the last outstanding digit.
- Reset asserted mid-capture: everything returns to reset values immediately. After release, a steady bus is recaptured after STABLE_CYCLES+1 edges.

## Configuration
- SEVENSEG_ERRCNT_EN:
  - Defined: err_count exists and increments on every pattern_err, saturating at 255.
  - Undefined: the err_count port and its register are absent. All other behaviour is identical.

## Structure
- sevenseg_pkg contains:
  - SEG_0…SEG_F and SEG_BLANK pattern constants, shared with the encoder.
  - The FSM state enum (SETTLE, CAPTURE, HOLD).
- Sub-module sevenseg_pattern_decode: purely combinational, maps 7-bit pattern → {hit, blank, nibble}.

## Test plan
- Reset with the bus driven → all outputs 0 until STABLE_CYCLES+1 edges after release.
- an_L=11111110, seg=0110000 held 6 cycles → hex_out[3:0]=3 and digit_valid[0]=1 at edge 5, no pattern_err.
- Same pattern held 3 cycles then changed to all-ones → no capture, hex_out and digit_valid stay 0.
- Scan digits 0..7 showing 0..7, 6 cycles each → hex_out=32'h76543210, digit_valid=8'hFF, exactly one frame_done one cycle after digit 7's capture.
- Digit 2 driven with seg=1010101 → one pattern_err pulse, digit_valid[2]=0; with macro, err_count=1.
- an_L=11111100 held 10 cycles → no capture. clear pulsed on the capture cycle of a valid digit → outputs 0 and no recapture while the input stays steady.
